// File: rtl/ula_div_sequencer.sv
// Iterative signed divider for the ULA divide path.
// Performs one restoring-division step per clock, starting at the MSB.
// Uses ready/valid handshakes on both the request and the response side.
module ula_div_sequencer #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cancel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 sign_flag,
  output logic                 zero_flag,
  output logic                 div_by_zero
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     mag_a, mag_b, rem, q;
  logic [SW-1:0]        step;
  logic                 sign_q, sign_r;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       rem_sh;
  logic                 ge;
  logic [WIDTH-1:0]     rem_nx, q_nx, rem_sgn;
  logic [OUT_WIDTH-1:0] q_ext, res_nx;
  logic                 accept;

  // -128 maps to 0x80, which still fits in WIDTH bits as an unsigned magnitude.
  assign abs_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign abs_b  = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign accept = (state == IDLE) && in_valid && !cancel;

  // Shift in the next dividend bit, then compare and subtract.
  // The running remainder is always below |b|, so its low WIDTH bits are enough.
  always_comb begin
    rem_sh   = {rem, mag_a[step]};
    ge       = rem_sh >= {1'b0, mag_b};
    rem_nx   = ge ? (rem_sh[WIDTH-1:0] - mag_b) : rem_sh[WIDTH-1:0];
    q_nx     = q;
    q_nx[step] = ge;
    q_ext    = {{(OUT_WIDTH-WIDTH){1'b0}}, q_nx};
    res_nx   = sign_q ? -q_ext : q_ext;
    rem_sgn  = sign_r ? -rem_nx : rem_nx;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic. Cancel wins over a new request and over the handshake.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (b == '0) ? DONE : CALC;
      CALC: if (cancel) state_nx = IDLE;
            else if (step == '0) state_nx = DONE;
      DONE: if (cancel || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latching, iteration registers and the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_a <= '0; mag_b <= '0; rem <= '0; q <= '0; step <= '0;
      sign_q <= 1'b0; sign_r <= 1'b0;
      result <= '0; remainder <= '0; div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mag_a  <= abs_a;
          mag_b  <= abs_b;
          sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
          sign_r <= a[WIDTH-1];
          rem    <= '0;
          q      <= '0;
          step   <= SW'(WIDTH-1);
          if (b == '0) begin
            result      <= '0;
            remainder   <= a;
            div_by_zero <= 1'b1;
          end
        end
        CALC: if (!cancel) begin
          rem  <= rem_nx;
          q    <= q_nx;
          step <= step - 1'b1;
          if (step == '0) begin
            result      <= res_nx;
            remainder   <= rem_sgn;
            div_by_zero <= 1'b0;
          end
        end
        DONE: if (cancel || out_ready) begin
          result <= '0; remainder <= '0; div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sign_flag = result[OUT_WIDTH-1];
  assign zero_flag = (state == DONE) && (result == '0);

endmodule

// File: tb/tb_ula_div_sequencer.sv
// Randomized self-checking bench for ula_div_sequencer against an integer-arithmetic model.
module tb_ula_div_sequencer;

  localparam int WIDTH = 8;
  localparam int OUT_WIDTH = 16;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, cancel, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, remainder;
  logic [OUT_WIDTH-1:0] result;
  logic sign_flag, zero_flag, div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  ula_div_sequencer #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cancel(cancel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .remainder(remainder), .sign_flag(sign_flag),
    .zero_flag(zero_flag), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer division (truncates toward zero, remainder follows dividend).
  function automatic void model(input logic [7:0] ta, input logic [7:0] tb_,
                                output logic [15:0] er, output logic [7:0] erm, output logic edz);
    int ai, bi, qi, ri;
    ai = int'($signed(ta));
    bi = int'($signed(tb_));
    if (bi == 0) begin
      er = '0; erm = ta; edz = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      er = qi[15:0]; erm = ri[7:0]; edz = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input int bp);
    logic [15:0] er;
    logic [7:0]  erm;
    logic        edz;
    logic [15:0] held;
    int lat;
    model(ta, tb_, er, erm, edz);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = ta; b = tb_;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (tb_ == 8'h00) ? 0 : WIDTH);
    chk("result", result, er);
    chk("remainder", remainder, erm);
    chk("sign_flag", sign_flag, er[15]);
    chk("zero_flag", zero_flag, (er == 16'h0) ? 1 : 0);
    chk("div_by_zero", div_by_zero, edz);
    held = result;
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, held);
      chk("bp_remainder", remainder, erm);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_result", result, 0);
  endtask

  task automatic abort_mid(input bit use_reset);
    @(negedge clk);
    in_valid = 1'b1; a = 8'd100; b = 8'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);          // iteration now at step 3
    if (use_reset) reset = 1'b1; else cancel = 1'b1;
    @(negedge clk);
    reset = 1'b0; cancel = 1'b0;
    chk(use_reset ? "rst_abort_valid" : "cxl_abort_valid", out_valid, 0);
    chk(use_reset ? "rst_abort_ready" : "cxl_abort_ready", in_ready, 1);
    chk(use_reset ? "rst_abort_result" : "cxl_abort_result", result, 0);
    run_op(8'd9, 8'd3, 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; cancel = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_flags", {sign_flag, zero_flag, div_by_zero}, 0);

    // Directed corners.
    run_op(8'd100, 8'd7, 0);
    run_op(8'h9C, 8'd7, 0);
    run_op(8'h80, 8'hFF, 0);
    run_op(8'd5, 8'd9, 0);
    run_op(8'd42, 8'd0, 0);
    run_op(8'd100, 8'd7, 5);
    run_op(8'h80, 8'h80, 1);
    run_op(8'h7F, 8'h80, 0);

    abort_mid(1'b1);
    abort_mid(1'b0);

    // Cancel in IDLE blocks acceptance.
    @(negedge clk);
    in_valid = 1'b1; cancel = 1'b1; a = 8'd20; b = 8'd4;
    @(negedge clk);
    in_valid = 1'b0; cancel = 1'b0;
    chk("idle_cxl_ready", in_ready, 1);
    chk("idle_cxl_valid", out_valid, 0);

    // Cancel while the result is waiting.
    @(negedge clk);
    in_valid = 1'b1; a = 8'd50; b = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (WIDTH) @(negedge clk);
    chk("done_before_cxl", out_valid, 1);
    chk("done_before_cxl_res", result, 16'd10);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("done_cxl_valid", out_valid, 0);
    chk("done_cxl_result", result, 0);
    chk("done_cxl_ready", in_ready, 1);

    // Randomized operands, with divisor zero forced now and then.
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
